// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage constants and FSM encoding for the instruction front end.
package pc_fetch_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fs_t;

endpackage

// File: rtl/pc_fetch_adder.sv
// Shared 32-bit wrap-around adder; instantiated by the fetch stage for pc + PC_STEP.
module pc_fetch_adder
  import pc_fetch_pkg::*;
(
  input  logic [XLEN-1:0] in0,
  input  logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] sum
);

  assign sum = in0 + in1;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding SRAM-like fetch,
// branch/flush redirects with in-flight cancel, and the {pc, inst, adel} hand-off to decode.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = pc_fetch_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = pc_fetch_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);
  import pc_fetch_pkg::*;

  fs_t         state_q, state_d;
  logic [31:0] pc_q, pc_seq, pend_pc_q, redir_pc;
  logic        pend_q, cancel_q, run_q;
  logic        redirect, misalign, accept, stale_only;

  pc_fetch_adder u_adder (
    .in0 (pc_q),
    .in1 (PC_STEP),
    .sum (pc_seq)
  );

  assign redirect   = flush | br_taken;
  assign redir_pc   = flush ? flush_pc : br_target;
  assign misalign   = (pc_q[1:0] != 2'b00);
  assign accept     = inst_req & inst_addr_ok;
  // cancel without a pending target only comes from a reset taken in WAIT:
  // one stale response is still owed by the memory and must be swallowed.
  assign stale_only = cancel_q & ~pend_q;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= FS_REQ;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_REQ: begin
        if (accept)                                state_d = FS_WAIT;
        else if (run_q && misalign && !redirect)   state_d = FS_HOLD;
      end
      FS_WAIT: begin
        if (inst_data_ok && !stale_only) begin
          if (cancel_q || redirect) state_d = FS_REQ;
          else                      state_d = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (redirect || (!stall && !if_adel)) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_comb begin
    inst_req  = run_q && (state_q == FS_REQ) && !misalign;
    inst_addr = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      cancel_q  <= (state_q == FS_WAIT);
      run_q     <= 1'b0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_inst   <= '0;
      if_adel   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        FS_REQ: begin
          if (inst_data_ok && stale_only) cancel_q <= 1'b0;
          if (redirect) begin
            // A presented request cannot be withdrawn: keep the address, park the target.
            if (inst_req) begin
              pend_q    <= 1'b1;
              pend_pc_q <= redir_pc;
              cancel_q  <= 1'b1;
            end else begin
              pc_q <= redir_pc;
            end
          end else if (run_q && misalign) begin
            if_valid <= 1'b1;
            if_adel  <= 1'b1;
            if_inst  <= '0;
            if_pc    <= pc_q;
          end
        end
        FS_WAIT: begin
          if (inst_data_ok) begin
            if (stale_only) begin
              cancel_q <= redirect;
              pend_q   <= redirect;
              if (redirect) pend_pc_q <= redir_pc;
            end else if (redirect) begin
              pc_q     <= redir_pc;
              pend_q   <= 1'b0;
              cancel_q <= 1'b0;
            end else if (cancel_q) begin
              pc_q     <= pend_pc_q;
              pend_q   <= 1'b0;
              cancel_q <= 1'b0;
            end else begin
              if_valid <= 1'b1;
              if_adel  <= 1'b0;
              if_inst  <= inst_rdata;
              if_pc    <= pc_q;
            end
          end else if (redirect) begin
            pend_q    <= 1'b1;
            pend_pc_q <= redir_pc;
            cancel_q  <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
            pc_q     <= redir_pc;
            pend_q   <= 1'b0;
          end else if (!stall && !if_adel) begin
            if_valid <= 1'b0;
            pc_q     <= pc_seq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed cycle-by-cycle bench for pc_fetch: a table of per-cycle inputs and expected
// outputs, followed by a hand-written mid-operation reset with a stale memory response.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        resetn, stall, br_taken, flush;
  logic [31:0] br_target, flush_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        if_valid, if_adel;
  logic [31:0] if_pc, if_inst;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_fetch #(.RESET_PC(32'hBFC0_0000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br, fl, aok, dok;
    logic [31:0] brt, flpc, rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc, iinst;
    logic        adel;
  } vec_t;

  vec_t vq[$];

  localparam logic [32-1:0] A0 = 32'h2408_0001, A1 = 32'h2409_0002, A2 = 32'h240A_0003;
  localparam logic [32-1:0] B0 = 32'h0810_0040, C0 = 32'h4080_6000, C1 = 32'h0000_000C;
  localparam logic [32-1:0] D0 = 32'h1111_2222, D1 = 32'h3C01_BFC0, E0 = 32'h8C22_0004;
  localparam logic [32-1:0] STALE = 32'hDEAD_BEEF;

  task automatic row(input logic st, input logic br, input logic [31:0] brt,
                     input logic fl, input logic [31:0] flpc,
                     input logic aok, input logic dok, input logic [31:0] rd,
                     input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] ipc, input logic [31:0] iinst,
                     input logic adel);
    vec_t r;
    r.stall = st; r.br = br; r.brt = brt; r.fl = fl; r.flpc = flpc;
    r.aok = aok; r.dok = dok; r.rdata = rd;
    r.req = req; r.addr = addr; r.v = v; r.ipc = ipc; r.iinst = iinst; r.adel = adel;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; br_target = '0; flush = 1'b0; flush_pc = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_100;
    int   n;
    seen_100 = 1'b0;

    //   st br brt            fl flpc           aok dok rdata  | req addr          v ipc            iinst adel
    row(0, 0, 0,            0, 0,            0, 0, 0,      1, 32'hBFC00000, 0, 0, 0, 0);     // r0
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00000, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, A0,     0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            1, 32'hBFC00000, A0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      1, 32'hBFC00004, 0, 0, 0, 0);     // r5
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00004, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, A1,     0, 0,            0, 0, 0, 0);
    for (int unsigned k = 0; k < 5; k++)                                                    // r9-r13 stalled
      row(1, 0, 0,          0, 0,            0, 0, 0,      0, 0,            1, 32'hBFC00004, A1, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            1, 32'hBFC00004, A1, 0); // r14
    row(0, 0, 0,            0, 0,            0, 0, 0,      1, 32'hBFC00008, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00008, 0, 0, 0, 0);
    row(0, 1, 32'hBFC00100, 0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);     // r17 branch in WAIT
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, A2,     0, 0,            0, 0, 0, 0);     // r19 dropped
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00100, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, B0,     0, 0,            0, 0, 0, 0);
    row(1, 1, 32'hBFC00100, 1, 32'hBFC00380, 0, 0, 0,      0, 0,            1, 32'hBFC00100, B0, 0); // r23
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00380, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, C0,     0, 0,            0, 0, 0, 0);     // r25
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            1, 32'hBFC00380, C0, 0);
    row(0, 1, 32'hBFC00102, 0, 0,            0, 0, 0,      1, 32'hBFC00384, 0, 0, 0, 0);     // r27 branch before accept
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00384, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, C1,     0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);     // r30 misaligned
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            1, 32'hBFC00102, 0, 1);
    row(0, 0, 0,            0, 0,            0, 1, 32'hFFFFFFFF, 0, 0,      1, 32'hBFC00102, 0, 1);
    row(0, 0, 0,            1, 32'hBFC00380, 0, 0, 0,      0, 0,            1, 32'hBFC00102, 0, 1);
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00380, 0, 0, 0, 0);     // r34
    row(0, 1, 32'hBFC00010, 0, 0,            0, 1, D0,     0, 0,            0, 0, 0, 0);     // r35 data+branch
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hBFC00010, 0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 1, D1,     0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            1, 32'hFFFFFFFC, 0, 0, 0,      0, 0,            1, 32'hBFC00010, D1, 0);
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'hFFFFFFFC, 0, 0, 0, 0);     // r39
    row(0, 0, 0,            0, 0,            0, 1, E0,     0, 0,            0, 0, 0, 0);
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            1, 32'hFFFFFFFC, E0, 0);
    row(0, 0, 0,            0, 0,            1, 0, 0,      1, 32'h00000000, 0, 0, 0, 0);     // r42 wrapped
    row(0, 0, 0,            0, 0,            0, 0, 0,      0, 0,            0, 0, 0, 0);

    // Power-on reset: every output idle except the reset address.
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst inst_req",  inst_req,  0);
    chk("rst inst_addr", inst_addr, 32'hBFC00000);
    chk("rst if_valid",  if_valid,  0);
    chk("rst if_pc",     if_pc,     0);
    chk("rst if_inst",   if_inst,   0);
    chk("rst if_adel",   if_adel,   0);
    resetn = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      chk($sformatf("r%0d inst_req", i), inst_req, vq[i].req);
      if (vq[i].req) chk($sformatf("r%0d inst_addr", i), inst_addr, vq[i].addr);
      chk($sformatf("r%0d if_valid", i), if_valid, vq[i].v);
      if (vq[i].v) begin
        chk($sformatf("r%0d if_pc", i),   if_pc,   vq[i].ipc);
        chk($sformatf("r%0d if_inst", i), if_inst, vq[i].iinst);
        chk($sformatf("r%0d if_adel", i), if_adel, vq[i].adel);
      end
      if (i > 23 && inst_req && inst_addr == 32'hBFC00100) seen_100 = 1'b1;
      stall = vq[i].stall; br_taken = vq[i].br; br_target = vq[i].brt;
      flush = vq[i].fl; flush_pc = vq[i].flpc;
      inst_addr_ok = vq[i].aok; inst_data_ok = vq[i].dok; inst_rdata = vq[i].rdata;
    end
    chk("flush beats branch: BFC00100 not refetched", seen_100, 0);

    // Reset taken while a fetch is outstanding; its late response must not reach decode.
    @(negedge clk);
    idle_inputs();
    chk("t6 in WAIT inst_req", inst_req, 0);
    resetn = 1'b0;
    @(negedge clk);
    chk("t6 rst inst_req",  inst_req,  0);
    chk("t6 rst inst_addr", inst_addr, 32'hBFC00000);
    chk("t6 rst if_valid",  if_valid,  0);
    resetn = 1'b1;
    n = 0;
    @(negedge clk);
    while (!inst_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("t6 inst_req after release", inst_req, 1);
    chk("t6 inst_addr", inst_addr, 32'hBFC00000);
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    chk("t6 WAIT inst_req", inst_req, 0);
    inst_data_ok = 1'b1; inst_rdata = STALE;
    @(negedge clk);
    chk("t6 stale dropped if_valid", if_valid, 0);
    inst_data_ok = 1'b1; inst_rdata = A0;
    @(negedge clk);
    idle_inputs();
    chk("t6 if_valid", if_valid, 1);
    chk("t6 if_pc",    if_pc,    32'hBFC00000);
    chk("t6 if_inst",  if_inst,  A0);
    chk("t6 if_adel",  if_adel,  0);
    @(negedge clk);
    chk("t6 next inst_addr", inst_addr, 32'hBFC00004);
    chk("t6 next inst_req",  inst_req,  1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
